// File: rtl/system_widths_pkg.sv
// ---------------------------------------------------------------------------
// system_widths_pkg
// Shared system-wide bus widths used as parameter defaults by the memory
// subsystem blocks.
// ---------------------------------------------------------------------------
package system_widths_pkg;
  localparam int ADDR_W = 16;
endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single cache request/response port between NUM_REQ memory
// requesters with exactly one transaction outstanding at a time.
//
// - Arbitration is round-robin. The search starts just after the requester
//   that completed last.
// - The winner's request is latched into the cache_req_* registers and
//   presented to the cache until the cache accepts it.
// - The cache response is returned as a one-cycle resp_valid pulse to the
//   owning requester only.
//
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; ready is combinational,
//                        one-hot or zero, and asserted only in IDLE
//   req_we/addr/wdata    per-requester request fields; packed buses, with
//                        requester i in slice i
//   resp_valid           one-cycle completion pulse to the owner
//   resp_data            registered load data, shared by all requesters
//   resp_err             response-timeout flag (MEM_ARB_TIMEOUT_EN only)
//   cache_req_*          latched request towards the cache
//   cache_resp_*         response from the cache
//
// Build option:
//   MEM_ARB_TIMEOUT_EN   adds a response watchdog of TIMEOUT_CYC cycles and
//                        the resp_err port. When it is undefined, WAIT_RESP
//                        waits for the response indefinitely.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = system_widths_pkg::ADDR_W,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                      resp_err,
`endif
  output logic                      cache_req_valid,
  input  logic                      cache_req_ready,
  output logic                      cache_req_we,
  output logic [ADDR_W-1:0]         cache_req_addr,
  output logic [DATA_W-1:0]         cache_req_write,
  input  logic                      cache_resp_valid,
  input  logic [DATA_W-1:0]         cache_resp_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_RESP = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [IDX_W-1:0]     last_grant_r;
  logic [IDX_W-1:0]     owner_r;
  logic                 cache_req_valid_r;
  logic                 cache_req_we_r;
  logic [ADDR_W-1:0]    cache_req_addr_r;
  logic [DATA_W-1:0]    cache_req_write_r;
  logic [NUM_REQ-1:0]   resp_valid_r;
  logic [DATA_W-1:0]    resp_data_r;

  logic                 found_s;
  logic [IDX_W-1:0]     winner_s;
  logic [IDX_W:0]       scan_sum_s;
  logic [IDX_W-1:0]     scan_idx_s;
  logic                 sel_we_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_wdata_s;
  logic                 accept_s;
  logic                 complete_s;
  logic                 timeout_s;

  // Round-robin search: the first valid requester after last_grant_r,
  // wrapping modulo NUM_REQ. The sum needs one extra bit so that the wrap
  // subtraction works when NUM_REQ is not a power of two.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = '0;
    scan_sum_s = '0;
    scan_idx_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum_s = {1'b0, last_grant_r} + (IDX_W+1)'(k);
      if (scan_sum_s >= (IDX_W+1)'(NUM_REQ)) begin
        scan_sum_s = scan_sum_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[IDX_W-1:0];
      if (!found_s && req_valid[scan_idx_s]) begin
        found_s  = 1'b1;
        winner_s = scan_idx_s;
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // Select the winner's request fields from the packed input buses.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_s == IDX_W'(i)) begin
        sel_we_s    = req_we[i];
        sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
      end else begin
        sel_we_s    = sel_we_s;
        sel_addr_s  = sel_addr_s;
        sel_wdata_s = sel_wdata_s;
      end
    end
  end

  // The accept strobe is combinational, so a requester is granted in the
  // same cycle that it presents its request.
  always_comb begin
    req_ready = '0;
    if ((state_r == IDLE) && found_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s   = (state_r == IDLE) && found_s;
  // A response that arrives while the request is still in ISSUE (including
  // in the accept cycle) is not looked at.
  assign complete_s = (state_r == WAIT_RESP) && cache_resp_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] timer_r;
  logic             resp_err_r;

  // The watchdog counter reads 0 on the first WAIT_RESP cycle and counts
  // every cycle spent there. Outside WAIT_RESP it is held at 0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timer_r <= '0;
    end else if (state_r == WAIT_RESP) begin
      timer_r <= timer_r + CNT_W'(1);
    end else begin
      timer_r <= '0;
    end
  end

  // If a response arrives on the limit cycle, it wins over the timeout.
  assign timeout_s = (state_r == WAIT_RESP) && !cache_resp_valid &&
                     (timer_r == CNT_W'(TIMEOUT_CYC - 1));

  // The error flag is a one-cycle pulse that accompanies the timeout
  // completion.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      resp_err_r <= 1'b0;
    end else begin
      resp_err_r <= timeout_s;
    end
  end

  assign resp_err = resp_err_r;
`else
  logic unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Any illegal encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (cache_req_ready) begin
          state_nxt_s = WAIT_RESP;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (complete_s || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request latch, cache handshake, response routing and arbitration
  // history.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_grant_r      <= IDX_W'(NUM_REQ - 1);
      owner_r           <= '0;
      cache_req_valid_r <= 1'b0;
      cache_req_we_r    <= 1'b0;
      cache_req_addr_r  <= '0;
      cache_req_write_r <= '0;
      resp_valid_r      <= '0;
      resp_data_r       <= '0;
    end else begin
      resp_valid_r <= '0;
      if (accept_s) begin
        cache_req_valid_r <= 1'b1;
        cache_req_we_r    <= sel_we_s;
        cache_req_addr_r  <= sel_addr_s;
        cache_req_write_r <= sel_wdata_s;
        owner_r           <= winner_s;
      end else if ((state_r == ISSUE) && cache_req_ready) begin
        cache_req_valid_r <= 1'b0;
      end else begin
        cache_req_valid_r <= cache_req_valid_r;
      end
      if (complete_s) begin
        resp_valid_r[owner_r] <= 1'b1;
        last_grant_r          <= owner_r;
        // Stores return no data, so the last load value is kept.
        if (!cache_req_we_r) begin
          resp_data_r <= cache_resp_data;
        end else begin
          resp_data_r <= resp_data_r;
        end
      end else if (timeout_s) begin
        resp_valid_r[owner_r] <= 1'b1;
        last_grant_r          <= owner_r;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign cache_req_valid = cache_req_valid_r;
  assign cache_req_we    = cache_req_we_r;
  assign cache_req_addr  = cache_req_addr_r;
  assign cache_req_write = cache_req_write_r;
  assign resp_valid      = resp_valid_r;
  assign resp_data       = resp_data_r;

endmodule
